// File: rtl/bram_data_pkg.sv
// bram_data_pkg: shared FSM states and BRAM address constants for the BRAM writer
package bram_data_pkg;
  localparam int BRAM_ADDR_WIDTH = 9;
  localparam logic [BRAM_ADDR_WIDTH-1:0] BRAM_ADDR_IDLE = 9'h1ff;
  typedef enum logic [1:0] {IDLE, WRITE, VERIFY, DONE} state_t;
endpackage

// File: rtl/bram_rd_compare_pipe.sv
// bram_rd_compare_pipe: delays expected data by the BRAM read latency and flags read-back mismatches
// Ports: clk, rst_n (async active-low); i_vld/i_exp = expected entry for the address presented
// this cycle; rd_data = BRAM read data; o_mis = mismatch on the entry arriving this cycle.
module bram_rd_compare_pipe
  import bram_data_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_vld,
  input  logic [DATA_WIDTH-1:0] i_exp,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  o_mis
);
  logic [DATA_WIDTH-1:0] r_exp [RD_LATENCY];
  logic [RD_LATENCY-1:0] r_vld;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) r_exp[i] <= '0;
    end else begin
      r_vld[0] <= i_vld;
      r_exp[0] <= i_exp;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_exp[i] <= r_exp[i-1];
      end
    end
  end
  assign o_mis = r_vld[RD_LATENCY-1] & (r_exp[RD_LATENCY-1] != rd_data);
endmodule

// File: rtl/bram_data_parallel_writer.sv
// bram_data_parallel_writer: latches a wide word on a start edge and writes its entries into a BRAM, highest address first
// Ports: clk, rst_n (async active-low), start (rising edge requests a transfer), data_in (packed entries),
// rd_data (BRAM read data, verify only); adder/wr_en/wr_data drive the BRAM; busy, done (1-cycle pulse),
// error (sticky read-back mismatch). Macro BRAM_DATA_PARALLEL_WRITER_VERIFY_EN adds the read-back verify pass.
module bram_data_parallel_writer
  import bram_data_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int REAL_DEPTH = 128,
  parameter int RD_LATENCY = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [DATA_WIDTH*REAL_DEPTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0]            rd_data,
  output logic [BRAM_ADDR_WIDTH-1:0]       adder,
  output logic                             wr_en,
  output logic [DATA_WIDTH-1:0]            wr_data,
  output logic                             busy,
  output logic                             done,
  output logic                             error
);
  localparam logic [BRAM_ADDR_WIDTH-1:0] LAST_ADDR = BRAM_ADDR_WIDTH'(REAL_DEPTH - 1);
  state_t                           r_state, w_state_n;
  logic                             r_start_meta;
  logic [1:0]                       r_start;
  logic [DATA_WIDTH*REAL_DEPTH-1:0] r_shadow;
  logic [BRAM_ADDR_WIDTH-1:0]       r_adder, w_adder_n, w_addr_m1;
  logic                             r_wr_en, w_wr_en_n, r_busy, w_busy_n, r_done, w_done_n;
  logic [DATA_WIDTH-1:0]            r_wr_data, w_wr_data_n;
  logic                             w_accept;
  assign w_accept  = r_start[0] & ~r_start[1] & ~r_busy & (r_state == IDLE);
  assign w_addr_m1 = r_adder - 1'b1;
`ifdef BRAM_DATA_PARALLEL_WRITER_VERIFY_EN
  localparam logic [15:0] VERIFY_LAST = 16'(REAL_DEPTH + RD_LATENCY - 1);
  logic [15:0]           r_vcnt;
  logic                  r_error, w_mis, w_cmp_vld;
  logic [DATA_WIDTH-1:0] w_cmp_exp;
  // Address issue phase of VERIFY; the trailing RD_LATENCY cycles only drain the compare pipe.
  assign w_cmp_vld = (r_state == VERIFY) & (r_adder != BRAM_ADDR_IDLE);
  assign w_cmp_exp = w_cmp_vld ? r_shadow[r_adder*DATA_WIDTH +: DATA_WIDTH] : '0;
  bram_rd_compare_pipe #(.DATA_WIDTH(DATA_WIDTH), .RD_LATENCY(RD_LATENCY)) u_cmp (
    .clk(clk), .rst_n(rst_n), .i_vld(w_cmp_vld), .i_exp(w_cmp_exp), .rd_data(rd_data), .o_mis(w_mis)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vcnt  <= '0;
      r_error <= 1'b0;
    end else begin
      r_vcnt  <= (r_state == VERIFY) ? r_vcnt + 16'd1 : '0;
      r_error <= w_accept ? 1'b0 : (r_error | w_mis);
    end
  end
  assign error = r_error;
`else
  logic w_unused;
  assign w_unused = ^rd_data ^ (RD_LATENCY > 0);
  assign error    = 1'b0;
`endif
  always_comb begin
    w_state_n   = r_state;
    w_adder_n   = r_adder;
    w_wr_en_n   = r_wr_en;
    w_wr_data_n = r_wr_data;
    w_busy_n    = r_busy;
    w_done_n    = 1'b0;
    case (r_state)
      IDLE: if (w_accept) begin
        w_state_n   = WRITE;
        w_adder_n   = LAST_ADDR;
        w_wr_en_n   = 1'b1;
        w_wr_data_n = data_in[(REAL_DEPTH-1)*DATA_WIDTH +: DATA_WIDTH];
        w_busy_n    = 1'b1;
      end
      WRITE: if (r_adder == '0) begin
        w_wr_en_n   = 1'b0;
        w_wr_data_n = '0;
`ifdef BRAM_DATA_PARALLEL_WRITER_VERIFY_EN
        w_state_n   = VERIFY;
        w_adder_n   = LAST_ADDR;
`else
        w_state_n   = DONE;
        w_adder_n   = BRAM_ADDR_IDLE;
        w_busy_n    = 1'b0;
        w_done_n    = 1'b1;
`endif
      end else begin
        w_adder_n   = w_addr_m1;
        w_wr_data_n = r_shadow[w_addr_m1*DATA_WIDTH +: DATA_WIDTH];
      end
`ifdef BRAM_DATA_PARALLEL_WRITER_VERIFY_EN
      VERIFY: begin
        w_adder_n = (r_adder == '0 || r_adder == BRAM_ADDR_IDLE) ? BRAM_ADDR_IDLE : w_addr_m1;
        if (r_vcnt == VERIFY_LAST) begin
          w_state_n = DONE;
          w_adder_n = BRAM_ADDR_IDLE;
          w_busy_n  = 1'b0;
          w_done_n  = 1'b1;
        end
      end
`endif
      default: w_state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_start_meta <= 1'b0;
      r_start      <= 2'b00;
      r_shadow     <= '0;
      r_adder      <= BRAM_ADDR_IDLE;
      r_wr_en      <= 1'b0;
      r_wr_data    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_start_meta <= start;
      r_start      <= {r_start[0], r_start_meta};
      if (w_accept) r_shadow <= data_in;
      r_adder      <= w_adder_n;
      r_wr_en      <= w_wr_en_n;
      r_wr_data    <= w_wr_data_n;
      r_busy       <= w_busy_n;
      r_done       <= w_done_n;
    end
  end
  assign adder   = r_adder;
  assign wr_en   = r_wr_en;
  assign wr_data = r_wr_data;
  assign busy    = r_busy;
  assign done    = r_done;
endmodule
